// File: rtl/alu_cmd_issuer.sv
// Command issuer for the ALU operand/result interface: one command in flight,
// fixed-latency result capture, valid/ready response. Optional ALU_SELFCHECK_EN.
module alu_cmd_issuer #(
    parameter int unsigned SIZE  = 32,
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [SIZE-1:0] cmd_a,
    input  logic [SIZE-1:0] cmd_b,
    input  logic [2:0]      cmd_op,
    output logic [SIZE-1:0] alu_a,
    output logic [SIZE-1:0] alu_b,
    output logic [2:0]      alu_opcode,
    input  logic [SIZE-1:0] alu_res,
    input  logic            alu_carry,
    input  logic            alu_overflow,
    input  logic            alu_zero,
`ifdef ALU_SELFCHECK_EN
    input  logic [SIZE-1:0] ref_res,
    input  logic            ref_carry,
    output logic [CNT_W-1:0] mismatch_cnt,
`endif
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [SIZE-1:0] rsp_res,
    output logic [3:0]      rsp_flags,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_C = 4'(LAT);

    if (LAT < 1 || LAT > 15) begin : g_bad_lat
        $error("alu_cmd_issuer: LAT must be in 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("alu_cmd_issuer: CNT_W must be at least 1");
    end

    state_t     state, state_n;
    logic [3:0] cnt;
    logic       op_legal;
    logic       accept_legal;
    logic       accept_illegal;
    logic       capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n        = state;
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        accept_legal   = 1'b0;
        accept_illegal = 1'b0;
        capture        = 1'b0;
        op_legal       = (cmd_op != 3'd2) && (cmd_op != 3'd7);
        case (state)
            IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid && !rst) begin
                    accept_legal   = op_legal;
                    accept_illegal = ~op_legal;
                    state_n        = op_legal ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    capture = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // alu_* only change on a legal accept, so the ALU never sees a partial command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            cnt        <= '0;
            rsp_res    <= '0;
            rsp_flags  <= '0;
        end else begin
            if (accept_legal) begin
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
                alu_opcode <= cmd_op;
                cnt        <= LAT_C;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (accept_illegal) begin
                rsp_res   <= '0;
                rsp_flags <= 4'b1000;
            end else if (capture) begin
                rsp_res   <= alu_res;
                rsp_flags <= {1'b0, alu_carry, alu_overflow, alu_zero};
            end
        end
    end

`ifdef ALU_SELFCHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_cnt <= '0;
        end else if (capture && ((alu_res != ref_res) || (alu_carry != ref_carry))) begin
            if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
        end
    end
`endif

endmodule
